// File: rtl/test_seq_pkg.sv
// ----------------------------------------------------------------------------
// test_seq_pkg
// Shared types and constants for the on-chip test sequencer:
//   seq_state_e   - controller FSM states
//   result_e      - per-channel result encoding, used when decoding masks
//   MAX_TESTS     - upper bound on the number of test channels
//   decode_result - folds one channel's pass/fail/timeout bits into result_e
// ----------------------------------------------------------------------------
package test_seq_pkg;

    localparam int MAX_TESTS = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        ADVANCE,
        DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_PASS,
        RES_FAIL,
        RES_TIMEOUT
    } result_e;

    // A timeout is also a fail, so it is checked first.
    function automatic result_e decode_result(input logic pass_bit,
                                              input logic fail_bit,
                                              input logic timeout_bit);
        if (timeout_bit)   return RES_TIMEOUT;
        else if (fail_bit) return RES_FAIL;
        else if (pass_bit) return RES_PASS;
        else               return RES_NONE;
    endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// ----------------------------------------------------------------------------
// test_sequencer_if
// Start/done/pass handshake between the sequencer and its test channels.
//   test_start : sequencer -> channel, one-hot single-cycle start pulse
//   test_done  : channel -> sequencer, completion (level or pulse)
//   test_pass  : channel -> sequencer, verdict valid while test_done is high
// Modports: master (sequencer side), slave (channel side).
// ----------------------------------------------------------------------------
interface test_sequencer_if #(
    parameter int NUM_TESTS = 7
);
    logic [NUM_TESTS-1:0] test_start;
    logic [NUM_TESTS-1:0] test_done;
    logic [NUM_TESTS-1:0] test_pass;

    modport master (
        output test_start,
        input  test_done,
        input  test_pass
    );

    modport slave (
        input  test_start,
        output test_done,
        output test_pass
    );
endinterface

// File: rtl/seq_watchdog.sv
// ----------------------------------------------------------------------------
// seq_watchdog
// Per-test watchdog: a saturating cycle counter that never wraps.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : force the count to zero (has priority over enable)
//   enable    : count one cycle
//   expired   : count has reached TIMEOUT_CYCLES-1
// Parameter: TIMEOUT_CYCLES (>= 2)
// ----------------------------------------------------------------------------
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && (cnt_q != LAST))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/test_sequencer.sv
// ----------------------------------------------------------------------------
// test_sequencer
// Runs NUM_TESTS test channels one after another over a start/done/pass
// handshake, with a per-test watchdog, and collects pass/fail/timeout masks.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   go             : start a run (sampled only in IDLE or DONE)
//   ch             : channel handshake (test_sequencer_if.master)
//   busy           : run in progress
//   finished       : run complete, results stable
//   all_pass       : finished and no fail recorded
//   cur_test       : index of the active or last-run test
//   pass_mask, fail_mask, timeout_mask : per-test results
// Build option: TEST_SEQ_STOP_ON_FAIL_EN - stop the run at the first fail
// or timeout; cur_test then holds the failing index.
// ----------------------------------------------------------------------------
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter  int NUM_TESTS      = 7,
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int IDX_W          = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 go,
    test_sequencer_if.master     ch,
    output logic                 busy,
    output logic                 finished,
    output logic                 all_pass,
    output logic [IDX_W-1:0]     cur_test,
    output logic [NUM_TESTS-1:0] pass_mask,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);

    seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [NUM_TESTS-1:0] pass_q, pass_d;
    logic [NUM_TESTS-1:0] fail_q, fail_d;
    logic [NUM_TESTS-1:0] tmo_q, tmo_d;
    logic                 wd_clear, wd_enable, wd_expired;

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tmo_d     = tmo_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    pass_d  = '0;
                    fail_d  = '0;
                    tmo_d   = '0;
                    cur_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                wd_clear = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                wd_enable = 1'b1;
                // Done is checked before expiry so a late-but-valid verdict wins.
                if (ch.test_done[cur_q]) begin
                    if (ch.test_pass[cur_q]) pass_d[cur_q] = 1'b1;
                    else                     fail_d[cur_q] = 1'b1;
                    state_d = ADVANCE;
                end else if (wd_expired) begin
                    fail_d[cur_q] = 1'b1;
                    tmo_d[cur_q]  = 1'b1;
                    state_d       = ADVANCE;
                end
            end
            ADVANCE: begin
                if (cur_q == LAST_IDX) begin
                    state_d = DONE;
                end
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
                else if (fail_q[cur_q]) begin
                    state_d = DONE;
                end
`endif
                else begin
                    cur_d   = cur_q + IDX_W'(1);
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cur_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output
    // without passing through a flop.
    always_comb begin
        ch.test_start = '0;
        if (state_q == START) ch.test_start[cur_q] = 1'b1;
    end

    assign busy         = (state_q == START) || (state_q == WAIT) || (state_q == ADVANCE);
    assign finished     = (state_q == DONE);
    assign all_pass     = (state_q == DONE) && (fail_q == '0);
    assign cur_test     = cur_q;
    assign pass_mask    = pass_q;
    assign fail_mask    = fail_q;
    assign timeout_mask = tmo_q;

endmodule

// File: doc/test_sequencer.md
# test_sequencer

Parametrised on-chip test sequencer for the mini-cpu self-test harness. It runs NUM_TESTS unit-test channels (full adder, ripple adder, ALU, PC, immediate gen, register file, data memory, …) one after another over a start/done/pass handshake. A per-test watchdog catches channels that never complete. Results are collected into pass, fail and timeout masks, with an overall verdict. It replaces the fixed-duration, fixed-list testbench top with a synthesizable controller that can also run on an FPGA.

## Interface
- NUM_TESTS, 7, number of test channels (1..32)
- TIMEOUT_CYCLES, 1000, maximum cycles a channel may stay in WAIT before it is marked timed-out (≥2)
- IDX_W, $clog2(NUM_TESTS) (min 1), current-test index width (derived localparam)
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  asynchronous active-low reset
- go  in  1  start a run; sampled only in IDLE or DONE
- test_start  out  NUM_TESTS  one-hot, single-cycle start pulse to channel i
- test_done  in  NUM_TESTS  channel i completion, level or pulse
- test_pass  in  NUM_TESTS  channel i verdict, valid when test_done[i]=1
- busy  out  1  run in progress
- finished  out  1  run complete, results stable
- all_pass  out  1  finished and every executed test passed
- cur_test  out  IDX_W  index of the active or last-run test
- pass_mask / fail_mask / timeout_mask  out  NUM_TESTS  per-test results; timeout_mask ⊆ fail_mask

## Operation
- FSM states: IDLE, START, WAIT, ADVANCE, DONE.
- IDLE: go=1 clears all masks, sets cur_test=0 and moves to START.
- START: drives test_start[cur_test]=1 for exactly one cycle, clears the watchdog, then moves to WAIT.
- WAIT: the watchdog increments each cycle. Only test_done[cur_test] is observed; other channels' done/pass bits are ignored.
  - test_done[cur_test]=1: set pass_mask[i] if test_pass[i]=1, else set fail_mask[i]; then ADVANCE.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no done: set fail_mask[i] and timeout_mask[i]; then ADVANCE.
  - Done and timeout in the same cycle: done wins, and the pass/fail verdict is recorded normally.
- ADVANCE:
  - cur_test == NUM_TESTS-1: go to DONE.
  - Otherwise: cur_test+1, then START.
- DONE: finished=1 and all_pass = (fail_mask == 0). go=1 restarts exactly as from IDLE. Results hold until then.
- go while busy is ignored.
- The watchdog is a saturating counter of width $clog2(TIMEOUT_CYCLES)+1; it never wraps.
- Reset at any point, mid-run included: state=IDLE, every output 0, test_start=0. A channel interrupted mid-test is never given another pulse.

## Timing
- go sampled high in cycle n → test_start[0] high in cycle n+1 and busy high from n+1.
- Done sampled in WAIT cycle m → mask bit visible in m+1 (ADVANCE) → next test_start in m+2.
- Per-test overhead: 3 cycles plus channel latency. Timeout takes TIMEOUT_CYCLES WAIT cycles.
- finished and all_pass rise one cycle after the last ADVANCE. busy falls in the same cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- TEST_SEQ_STOP_ON_FAIL_EN defined: the first fail or timeout goes from ADVANCE straight to DONE. cur_test holds the failing index, and later tests stay 0 in all masks.
- TEST_SEQ_STOP_ON_FAIL_EN undefined: all NUM_TESTS channels always run.

## Structure
- Package test_seq_pkg:
  - seq_state_e enum (IDLE, START, WAIT, ADVANCE, DONE)
  - MAX_TESTS=32 constant
  - result_e enum (RES_NONE, RES_PASS, RES_FAIL, RES_TIMEOUT) for bench decoding
- Sub-module seq_watchdog: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES.

## Test plan
- NUM_TESTS=3, TIMEOUT=8; go, then each channel returns done+pass 2 cycles after its start → pass_mask=3'b111, fail_mask=0, all_pass=1, finished=1.
- Channel 1 returns pass=0 → pass_mask=3'b101, fail_mask=3'b010, timeout_mask=0, all_pass=0.
- Channel 2 never responds → timeout_mask=fail_mask=3'b100, flagged exactly 8 WAIT cycles after test_start[2].
- Done asserted on the watchdog's expiry cycle with pass=1 → pass bit set, timeout bit clear.
- rstn pulsed low during channel 1's WAIT → all outputs 0 immediately. A fresh go restarts at test_start[0] with cleared masks.
- TEST_SEQ_STOP_ON_FAIL_EN defined, channel 0 fails → finished 1 cycle after ADVANCE, cur_test=0, test_start[1] never pulses.
